pe_row_feeder: RTL and testbench

Transmit side of the PE-row load/compute/drain protocol. Sequences one job into a PE row:
- Streams PE_DIM weight words into the individual PEs.
- Broadcasts feature sub-vectors with their non-zero address lists and issues the acc pulses.
- Signals done, waits for every PE's out_vd, then reads out the PE_DIM partial sums and forwards them to the output buffer over a valid/ready handshake.

---
 rtl/pe_row_feeder.sv | 185 ++++++++++++++++++
 tb/tb_pe_row_feeder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_feeder.sv
// Transmit-side sequencer for one PE row: loads weights, broadcasts features with
// their accumulate pulses, then collects the row's partial sums for the output buffer.
module pe_row_feeder #(
  parameter int MAC_DIM      = 5,
  parameter int FEAT_WIDTH   = 8,
  parameter int SPAD_WIDTH   = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int PE_DIM       = 16,
  parameter int ADDR_WIDTH   = $clog2(SPAD_WIDTH),
  parameter int LOG_PE_DIM   = $clog2(PE_DIM)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [15:0]                      cfg_num_feat,
  input  logic                             src_valid,
  output logic                             src_ready,
  input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] src_data,
  input  logic [ADDR_WIDTH*MAC_DIM-1:0]    src_addr,
  input  logic [2:0]                       src_nz,
  output logic [FEAT_WIDTH*SPAD_WIDTH-1:0] data_bus,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]    non_zero_add_bus,
  output logic [2:0]                       non_zero_num,
  output logic [LOG_PE_DIM-1:0]            weight_enable_top,
  output logic                             wgt_valid,
  output logic                             broad_cast_enable,
  output logic                             acc,
  output logic                             done,
  output logic                             psum_rd,
  input  logic [PE_DIM-1:0]                out_vd,
  input  logic [PE_OUT_WIDTH*PE_DIM-1:0]   sum_out_bus,
  output logic                             psum_valid,
  input  logic                             psum_ready,
  output logic [PE_OUT_WIDTH*PE_DIM-1:0]   psum_data,
  output logic                             busy,
  output logic                             job_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLOAD  = 3'd1;
  localparam logic [2:0] S_FEAT   = 3'd2;
  localparam logic [2:0] S_ACC    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
  localparam logic [2:0] S_WAITVD = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  localparam logic [2:0]            L_MAC_DIM  = 3'(MAC_DIM);
  localparam logic [LOG_PE_DIM-1:0] L_LAST_PE  = LOG_PE_DIM'(PE_DIM - 1);

  logic [2:0]                       r_state;
  logic [LOG_PE_DIM-1:0]            r_wcnt;
  logic [15:0]                      r_fcnt;
  logic [2:0]                       r_acnt;
  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] r_data_bus;
  logic [ADDR_WIDTH*MAC_DIM-1:0]    r_nz_add_bus;
  logic [2:0]                       r_nz_num;
  logic [LOG_PE_DIM-1:0]            r_wen_top;
  logic                             r_wgt_valid;
  logic                             r_bcast;
  logic                             r_acc;
  logic                             r_done;
  logic                             r_psum_rd;
  logic                             r_psum_valid;
  logic [PE_OUT_WIDTH*PE_DIM-1:0]   r_psum_data;
  logic                             r_job_done;

  logic                             w_src_hs;
  logic [2:0]                       w_nz_clamp;
  logic [15:0]                      w_fcnt_dec;
  logic                             w_all_vd;

  assign src_ready  = (r_state == S_WLOAD) || (r_state == S_FEAT);
  assign busy       = (r_state != S_IDLE);
  assign w_src_hs   = src_valid && src_ready;
  assign w_nz_clamp = (src_nz > L_MAC_DIM) ? L_MAC_DIM : src_nz;
  assign w_fcnt_dec = r_fcnt - 16'd1;
  assign w_all_vd   = &out_vd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_fcnt       <= '0;
      r_acnt       <= '0;
      r_data_bus   <= '0;
      r_nz_add_bus <= '0;
      r_nz_num     <= '0;
      r_wen_top    <= '0;
      r_wgt_valid  <= 1'b0;
      r_bcast      <= 1'b0;
      r_acc        <= 1'b0;
      r_done       <= 1'b0;
      r_psum_rd    <= 1'b0;
      r_psum_valid <= 1'b0;
      r_psum_data  <= '0;
      r_job_done   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the state below re-raises one.
      r_wgt_valid <= 1'b0;
      r_bcast     <= 1'b0;
      r_acc       <= 1'b0;
      r_done      <= 1'b0;
      r_psum_rd   <= 1'b0;
      r_job_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WLOAD;
            r_fcnt  <= cfg_num_feat;
            r_wcnt  <= '0;
          end
        end
        S_WLOAD: begin
          if (w_src_hs) begin
            r_data_bus  <= src_data;
            r_wen_top   <= r_wcnt;
            r_wgt_valid <= 1'b1;
            r_wcnt      <= r_wcnt + 1'b1;
            if (r_wcnt == L_LAST_PE) begin
              r_state <= (r_fcnt != 16'd0) ? S_FEAT : S_FIN;
            end
          end
        end
        S_FEAT: begin
          if (w_src_hs) begin
            r_data_bus   <= src_data;
            r_nz_add_bus <= src_addr;
            r_nz_num     <= w_nz_clamp;
            r_bcast      <= 1'b1;
            r_fcnt       <= w_fcnt_dec;
            if (w_nz_clamp != 3'd0) begin
              r_acnt  <= w_nz_clamp;
              r_state <= S_ACC;
            end else begin
              r_state <= (w_fcnt_dec != 16'd0) ? S_FEAT : S_FIN;
            end
          end
        end
        S_ACC: begin
          // One acc per ACC cycle; the registered output lags the state by one,
          // which lands the first pulse right after the broadcast strobe.
          r_acc  <= 1'b1;
          r_acnt <= r_acnt - 3'd1;
          if (r_acnt == 3'd1) begin
            r_state <= (r_fcnt != 16'd0) ? S_FEAT : S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_WAITVD;
        end
        S_WAITVD: begin
          if (w_all_vd) begin
            r_psum_rd    <= 1'b1;
            r_psum_data  <= sum_out_bus;
            r_psum_valid <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (psum_ready) begin
            r_job_done   <= 1'b1;
            r_psum_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_bus          = r_data_bus;
  assign non_zero_add_bus  = r_nz_add_bus;
  assign non_zero_num      = r_nz_num;
  assign weight_enable_top = r_wen_top;
  assign wgt_valid         = r_wgt_valid;
  assign broad_cast_enable = r_bcast;
  assign acc               = r_acc;
  assign done              = r_done;
  assign psum_rd           = r_psum_rd;
  assign psum_valid        = r_psum_valid;
  assign psum_data         = r_psum_data;
  assign job_done          = r_job_done;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Bench for pe_row_feeder: random jobs are driven through the source port and the
// observed strobe trace is compared with the event sequence the job should produce.
module tb_pe_row_feeder;

  localparam int EV_W = 1, EV_B = 2, EV_A = 3, EV_D = 4, EV_R = 5;

  logic         clk;
  logic         reset;
  logic         start;
  logic [15:0]  cfg_num_feat;
  logic         src_valid;
  logic         src_ready;
  logic [511:0] src_data;
  logic [29:0]  src_addr;
  logic [2:0]   src_nz;
  logic [511:0] data_bus;
  logic [29:0]  non_zero_add_bus;
  logic [2:0]   non_zero_num;
  logic [3:0]   weight_enable_top;
  logic         wgt_valid;
  logic         broad_cast_enable;
  logic         acc;
  logic         done;
  logic         psum_rd;
  logic [15:0]  out_vd;
  logic [127:0] sum_out_bus;
  logic         psum_valid;
  logic         psum_ready;
  logic [127:0] psum_data;
  logic         busy;
  logic         job_done;

  typedef struct {
    int           kind;
    int           val;
    logic [511:0] data;
    logic [29:0]  addr;
    int           cyc;
  } ev_t;

  ev_t  evq[$];
  ev_t  mon_ev;
  int   job_nz[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;

  pe_row_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_feat(cfg_num_feat),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_addr(src_addr), .src_nz(src_nz), .data_bus(data_bus),
    .non_zero_add_bus(non_zero_add_bus), .non_zero_num(non_zero_num),
    .weight_enable_top(weight_enable_top), .wgt_valid(wgt_valid),
    .broad_cast_enable(broad_cast_enable), .acc(acc), .done(done),
    .psum_rd(psum_rd), .out_vd(out_vd), .sum_out_bus(sum_out_bus),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .busy(busy), .job_done(job_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int clamp_nz(input int n);
    return (n > 5) ? 5 : n;
  endfunction

  function automatic ev_t get_ev(input int p);
    ev_t e;
    if (p < evq.size()) return evq[p];
    e.kind = -1; e.val = 0; e.data = '0; e.addr = '0; e.cyc = -1;
    return e;
  endfunction

  // Strobe trace recorder plus the every-cycle exclusivity rule.
  always @(negedge clk) begin
    int n;
    n = ((wgt_valid === 1'b1) ? 1 : 0) + ((broad_cast_enable === 1'b1) ? 1 : 0) +
        ((acc === 1'b1) ? 1 : 0) + ((done === 1'b1) ? 1 : 0) + ((psum_rd === 1'b1) ? 1 : 0);
    check("strobe_excl", (n <= 1), 1'b1);
    mon_ev.val = 0; mon_ev.data = data_bus; mon_ev.addr = non_zero_add_bus; mon_ev.cyc = cyc;
    mon_ev.kind = 0;
    if (wgt_valid === 1'b1) begin mon_ev.kind = EV_W; mon_ev.val = int'(weight_enable_top); end
    if (broad_cast_enable === 1'b1) begin mon_ev.kind = EV_B; mon_ev.val = int'(non_zero_num); end
    if (acc === 1'b1) mon_ev.kind = EV_A;
    if (done === 1'b1) mon_ev.kind = EV_D;
    if (psum_rd === 1'b1) mon_ev.kind = EV_R;
    if (mon_ev.kind != 0) evq.push_back(mon_ev);
  end

  // vmode: 0 = source always valid, 1 = valid every other cycle, 2 = random valid.
  task automatic run_job(input int vmode, input int vd_delay, input int rdy_delay, input bit extra);
    logic [511:0] words[$];
    logic [29:0]  addrs[$];
    int           nzs[$];
    int           nf, idx, guard, start_cyc, p, bcyc, dcyc, nc, span;
    bit           hs, tog;
    logic [127:0] sums;
    ev_t          e;
    nf = job_nz.size();
    for (int i = 0; i < 16 + nf; i++) begin
      words.push_back(rand512());
      addrs.push_back(30'($urandom));
      nzs.push_back((i < 16) ? int'($urandom_range(0, 7)) : job_nz[i-16]);
    end
    evq.delete();
    out_vd = 16'h7FFF; psum_ready = 1'b0; sum_out_bus = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b1; cfg_num_feat = 16'(nf); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    idx = 0; hs = 1'b0; tog = 1'b0; guard = 0;
    while (guard < 3000) begin
      if (hs) idx++;
      if (idx >= words.size()) break;
      src_valid = (vmode == 0) ? 1'b1 : ((vmode == 1) ? tog : 1'($urandom));
      tog = !tog;
      src_data = words[idx]; src_addr = addrs[idx]; src_nz = 3'(nzs[idx]);
      if (extra) start = ($urandom_range(0, 2) == 0);
      hs = src_valid && src_ready;
      @(negedge clk);
      guard++;
    end
    src_valid = 1'b0; start = 1'b0;
    check("src_words_taken", idx, words.size());
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    check("done_seen", done, 1'b1);
    for (int k = 0; k < vd_delay; k++) begin
      @(negedge clk);
      check("no_rd_before_all_vd", psum_rd, 1'b0);
    end
    sums = {$urandom, $urandom, $urandom, $urandom};
    out_vd = 16'hFFFF; sum_out_bus = sums;
    @(negedge clk);
    check("psum_rd", psum_rd, 1'b1);
    check("psum_valid", psum_valid, 1'b1);
    check("psum_data", psum_data, sums);
    out_vd = 16'h7FFF; sum_out_bus = ~sums;
    for (int k = 0; k < rdy_delay; k++) begin
      @(negedge clk);
      check("psum_valid_held", psum_valid, 1'b1);
      check("psum_data_held", psum_data, sums);
      check("no_early_job_done", job_done, 1'b0);
    end
    psum_ready = 1'b1; start = extra;
    @(negedge clk);
    psum_ready = 1'b0; start = 1'b0;
    check("job_done", job_done, 1'b1);
    check("psum_valid_clear", psum_valid, 1'b0);
    check("idle_after_job", busy, 1'b0);
    @(negedge clk);
    check("still_idle", busy, 1'b0);
    check("job_done_one_cycle", job_done, 1'b0);

    // Expected trace: 16 weights, per feature a broadcast then clamp(nz) accs, done, psum_rd.
    p = 0; span = 0;
    for (int i = 0; i < 16; i++) begin
      e = get_ev(p); p++;
      check("wgt_kind", e.kind, EV_W);
      check("wgt_index", e.val, i);
      check("wgt_data", e.data, words[i]);
      if (i == 0 && vmode == 0) check("first_wgt_cycle", e.cyc, start_cyc + 2);
    end
    for (int f = 0; f < nf; f++) begin
      nc = clamp_nz(job_nz[f]);
      span += 1 + nc;
      e = get_ev(p); p++;
      bcyc = e.cyc;
      check("bcast_kind", e.kind, EV_B);
      check("bcast_nz_num", e.val, nc);
      check("bcast_data", e.data, words[16+f]);
      check("bcast_addr", e.addr, addrs[16+f]);
      for (int k = 1; k <= nc; k++) begin
        e = get_ev(p); p++;
        check("acc_kind", e.kind, EV_A);
        check("acc_cycle", e.cyc, bcyc + k);
      end
    end
    e = get_ev(p); p++;
    dcyc = e.cyc;
    check("done_kind", e.kind, EV_D);
    if (vmode == 0) check("done_cycle", dcyc, start_cyc + 18 + span);
    e = get_ev(p); p++;
    check("rd_kind", e.kind, EV_R);
    check("rd_cycle", e.cyc, dcyc + 1 + vd_delay);
    check("trace_length", evq.size(), p);
    $display("job: feats=%0d vmode=%0d vd_delay=%0d rdy_delay=%0d extra_starts=%0d events=%0d",
             nf, vmode, vd_delay, rdy_delay, extra, evq.size());
  endtask

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; cfg_num_feat = '0; src_valid = 1'b0; src_data = '0;
    src_addr = '0; src_nz = '0; out_vd = '0; sum_out_bus = '0; psum_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_wgt_valid", wgt_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_psum_valid", psum_valid, 1'b0);
    check("rst_data_bus", data_bus, '0);
    check("rst_psum_data", psum_data, '0);
    check("rst_job_done", job_done, 1'b0);

    job_nz = '{3, 5};
    run_job(0, 0, 0, 1'b0);
    job_nz = '{7, 0, 2};
    run_job(0, 0, 0, 1'b0);
    job_nz.delete();
    run_job(0, 0, 0, 1'b0);
    job_nz.delete();
    for (int i = 0; i < 3; i++) job_nz.push_back(int'($urandom_range(0, 7)));
    run_job(0, 10, 4, 1'b0);
    job_nz.delete();
    for (int i = 0; i < 3; i++) job_nz.push_back(int'($urandom_range(0, 7)));
    run_job(1, 2, 1, 1'b1);
    job_nz.delete();
    for (int i = 0; i < 4; i++) job_nz.push_back(int'($urandom_range(0, 7)));
    run_job(2, 0, 2, 1'b0);

    // Abort a job in the middle of its accumulate run.
    @(negedge clk);
    start = 1'b1; cfg_num_feat = 16'd1;
    @(negedge clk);
    start = 1'b0; src_valid = 1'b1; src_nz = 3'd5;
    guard = 0;
    while (acc !== 1'b1 && guard < 100) begin
      src_data = rand512();
      @(negedge clk);
      guard++;
    end
    check("acc_before_reset", acc, 1'b1);
    reset = 1'b1; src_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_acc", acc, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_src_ready", src_ready, 1'b0);
    check("abort_data_bus", data_bus, '0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_no_psum_rd", psum_rd, 1'b0);
    end
    $display("reset mid-acc: aborted");
    job_nz = '{1, 6};
    run_job(0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
